// File: rtl/ysyx_220053_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, write-back.
// Owns the PC, retirement counter and halt status of the ysyx_220053 core.
module ysyx_220053_seq_ctrl #(
  parameter logic [63:0]  RESET_PC = 64'h8000_0000,
  parameter int unsigned  TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_o,
  input  logic [6:0]  op,
  input  logic [2:0]  func3,
  input  logic [4:0]  rd,
  input  logic [63:0] immI,
  input  logic [63:0] next_pc,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        rf_wen,
  output logic [63:0] pc_o,
  output logic        retired,
  output logic [63:0] instret,
  output logic        halt,
  output logic [1:0]  halt_code
);

  localparam int unsigned WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] CODE_RUN     = 2'd0;
  localparam logic [1:0] CODE_EBREAK  = 2'd1;
  localparam logic [1:0] CODE_ILLEGAL = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [1:0]        code_n;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_run;
  logic              is_legal;
  logic              is_mem;
  logic              is_ebreak;
  logic              writes_rd;

  assign imem_addr = pc_o;

  // Opcode classification of the latched instruction
  always_comb begin
    is_legal = 1'b0;
    case (op)
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL,
      OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH: is_legal = 1'b1;
      default:                                   is_legal = 1'b0;
    endcase
    is_mem    = (op == OPC_LOAD) || (op == OPC_STORE);
    is_ebreak = (op == OPC_SYSTEM) && (func3 == 3'd0) && (immI == 64'd1);
    writes_rd = (op != OPC_STORE) && (op != OPC_BRANCH) && (rd != 5'd0);
  end

  // Next-state and strobe logic
  always_comb begin
    state_n  = state;
    code_n   = halt_code;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    rf_wen   = 1'b0;
    retired  = 1'b0;
    wait_run = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_n = S_DECODE;
        end else if (wait_cnt == WAIT_MAX) begin
          state_n = S_HALT;
          code_n  = CODE_TIMEOUT;
        end else begin
          wait_run = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_n = S_EXEC;
        end else if (is_ebreak) begin
          state_n = S_HALT;
          code_n  = CODE_EBREAK;
          retired = 1'b1;
        end else begin
          state_n = S_HALT;
          code_n  = CODE_ILLEGAL;
        end
      end
      S_EXEC: state_n = is_mem ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_n = S_WB;
        end else if (wait_cnt == WAIT_MAX) begin
          state_n = S_HALT;
          code_n  = CODE_TIMEOUT;
        end else begin
          wait_run = 1'b1;
        end
      end
      S_WB: begin
        rf_wen  = writes_rd;
        retired = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
    // Reset cycle: no requests or strobes escape, even though state is FETCH
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      rf_wen   = 1'b0;
      retired  = 1'b0;
    end
  end

  // State, architectural registers and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc_o      <= RESET_PC;
      instr_o   <= '0;
      instret   <= '0;
      halt      <= 1'b0;
      halt_code <= CODE_RUN;
      wait_cnt  <= '0;
    end else begin
      state     <= state_n;
      halt_code <= code_n;
      halt      <= halt || (state_n == S_HALT);
      if ((state == S_FETCH) && imem_ack) begin
        instr_o <= imem_rdata;
      end
      if (state == S_WB) begin
        pc_o <= next_pc;
      end
      if (retired) begin
        instret <= instret + 64'd1;
      end
      // Counter restarts on every state change, so it is zero on entry to FETCH/MEM
      if (state_n != state) begin
        wait_cnt <= '0;
      end else if (wait_run) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_220053_seq_ctrl.sv
// Directed bench for the sequencer: instruction table plus hand-written
// sequences for halt, timeout and mid-access reset.
module tb_ysyx_220053_seq_ctrl;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_o;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic [63:0] immI;
  logic [63:0] next_pc;
  logic        dmem_req;
  logic        dmem_ack;
  logic        rf_wen;
  logic [63:0] pc_o;
  logic        retired;
  logic [63:0] instret;
  logic        halt;
  logic [1:0]  halt_code;

  int nchk = 0;
  int nerr = 0;

  ysyx_220053_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_o(instr_o),
    .op(op), .func3(func3), .rd(rd), .immI(immI), .next_pc(next_pc),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .rf_wen(rf_wen),
    .pc_o(pc_o), .retired(retired), .instret(instret),
    .halt(halt), .halt_code(halt_code)
  );

  // Minimal decoder and sequential next-PC model
  assign op      = instr_o[6:0];
  assign func3   = instr_o[14:12];
  assign rd      = instr_o[11:7];
  assign immI    = {{52{instr_o[31]}}, instr_o[31:20]};
  assign next_pc = pc_o + 64'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] instr;
    int          dwait;
    int          cyc;
    int          dreq;
    bit          wen;
    bit          ret;
    bit          hlt;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_dmem_req", 64'(dmem_req), 64'd0);
    check("rst_pc", pc_o, RST_PC);
    check("rst_instret", instret, 64'd0);
    check("rst_halt", {61'd0, halt, halt_code}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction from a FETCH cycle until retirement or halt
  task automatic run_instr(input logic [31:0] w, input int dwait, output int cyc,
                           output int dreq, output bit wen, output bit ret);
    int dcnt;
    bit done;
    imem_rdata = w;
    cyc = 0; dreq = 0; wen = 0; ret = 0; dcnt = 0; done = 0;
    for (int i = 0; i < 600 && !done; i++) begin
      #1;
      cyc++;
      if (dmem_req) dreq++;
      if (rf_wen) wen = 1;
      if (retired) ret = 1;
      imem_ack = imem_req;
      dmem_ack = dmem_req && (dcnt >= dwait);
      if (dmem_req) dcnt++;
      done = retired || halt;
      if (!done) @(negedge clk);
    end
    if (!done) check("run_bound", 64'd0, 64'd1);
  endtask

  initial begin
    int cyc, dreq, n, bad;
    bit wen, ret;
    logic [63:0] exp_pc, exp_ir;

    vecs[0] = '{32'h0010_0093, 0, 4, 0, 1, 1, 0, 2'd0};  // addi x1,x0,1
    vecs[1] = '{32'h0010_0093, 0, 4, 0, 1, 1, 0, 2'd0};
    vecs[2] = '{32'h0010_0093, 0, 4, 0, 1, 1, 0, 2'd0};
    vecs[3] = '{32'h0000_2103, 3, 8, 4, 1, 1, 0, 2'd0};  // lw, ack after 3 waits
    vecs[4] = '{32'h0010_2023, 0, 5, 1, 0, 1, 0, 2'd0};  // sw
    vecs[5] = '{32'h0000_0063, 0, 4, 0, 0, 1, 0, 2'd0};  // beq
    vecs[6] = '{32'h0000_0013, 0, 4, 0, 0, 1, 0, 2'd0};  // addi x0 (rd=0)
    vecs[7] = '{32'h0000_02b7, 0, 4, 0, 1, 1, 0, 2'd0};  // lui x5
    vecs[8] = '{32'h0010_0073, 0, 2, 0, 0, 1, 1, 2'd1};  // ebreak

    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;

    // Instruction table
    do_reset();
    #1;
    check("first_imem_req", 64'(imem_req), 64'd1);
    check("first_imem_addr", imem_addr, RST_PC);
    exp_pc = RST_PC;
    exp_ir = 0;
    for (int i = 0; i < 9; i++) begin
      run_instr(vecs[i].instr, vecs[i].dwait, cyc, dreq, wen, ret);
      check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d_dmem_req_cycles", i), 64'(dreq), 64'(vecs[i].dreq));
      check($sformatf("v%0d_rf_wen", i), 64'(wen), 64'(vecs[i].wen));
      check($sformatf("v%0d_retired", i), 64'(ret), 64'(vecs[i].ret));
      if (!vecs[i].hlt) exp_pc = exp_pc + 64'd4;
      if (vecs[i].ret) exp_ir = exp_ir + 64'd1;
      @(negedge clk);
      #1;
      check($sformatf("v%0d_halt", i), 64'(halt), 64'(vecs[i].hlt));
      check($sformatf("v%0d_halt_code", i), 64'(halt_code), 64'(vecs[i].code));
      check($sformatf("v%0d_pc", i), pc_o, exp_pc);
      check($sformatf("v%0d_instret", i), instret, exp_ir);
    end

    // HALT absorbs stray acknowledges
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      #1;
      if (imem_req || dmem_req || rf_wen || retired || !halt) bad++;
    end
    check("halt_absorb", 64'(bad), 64'd0);
    check("halt_pc_frozen", pc_o, exp_pc);
    check("halt_instret_frozen", instret, exp_ir);
    check("halt_code_sticky", 64'(halt_code), 64'd1);

    // Illegal opcode
    do_reset();
    run_instr(32'h0000_0000, 0, cyc, dreq, wen, ret);
    check("illegal_cycles", 64'(cyc), 64'd3);
    check("illegal_retired", 64'(ret), 64'd0);
    @(negedge clk);
    #1;
    check("illegal_halt", 64'(halt), 64'd1);
    check("illegal_code", 64'(halt_code), 64'd2);
    check("illegal_instret", instret, 64'd0);
    check("illegal_pc", pc_o, RST_PC);

    // Fetch timeout: no acknowledge at all
    do_reset();
    imem_ack = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (halt) break;
      if (imem_req) n++;
      @(negedge clk);
    end
    check("timeout_halt", 64'(halt), 64'd1);
    check("timeout_code", 64'(halt_code), 64'd3);
    check("timeout_req_cycles", 64'(n), 64'd256);

    // Acknowledge on the final timeout cycle wins
    do_reset();
    imem_ack = 1'b0;
    repeat (255) begin
      #1;
      @(negedge clk);
    end
    run_instr(32'h0010_0093, 0, cyc, dreq, wen, ret);
    check("late_ack_cycles", 64'(cyc), 64'd4);
    check("late_ack_wen", 64'(wen), 64'd1);
    @(negedge clk);
    #1;
    check("late_ack_no_halt", {61'd0, halt, halt_code}, 64'd0);
    check("late_ack_instret", instret, 64'd1);

    // Reset during a MEM wait, late dmem_ack ignored
    do_reset();
    imem_rdata = 32'h0000_2103;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      imem_ack = imem_req;
      dmem_ack = 1'b0;
      if (dmem_req) n++;
      if (n == 3) break;
      @(negedge clk);
    end
    check("midmem_reached", 64'(n), 64'd3);
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b1;
    @(negedge clk);
    #1;
    check("midmem_rst_reqs", {62'd0, imem_req, dmem_req}, 64'd0);
    rst = 1'b0;
    #1;
    check("midmem_fetch_req", 64'(imem_req), 64'd1);
    check("midmem_fetch_addr", imem_addr, RST_PC);
    check("midmem_instret", instret, 64'd0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (!imem_req || dmem_req || rf_wen || retired) bad++;
    end
    check("midmem_late_dmem_ack", 64'(bad), 64'd0);
    run_instr(32'h0010_0093, 0, cyc, dreq, wen, ret);
    check("midmem_next_cycles", 64'(cyc), 64'd4);
    @(negedge clk);
    #1;
    check("midmem_next_pc", pc_o, RST_PC + 64'd4);
    check("midmem_next_instret", instret, 64'd1);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_seq_ctrl.md
# ysyx_220053_seq_ctrl

Multi-cycle instruction sequencer for the ysyx_220053 core. It fetches each instruction over a request/acknowledge instruction-memory port and latches it for the decoder. It uses the decoder's fields to step the instruction through execute, optional memory access and write-back, owning the PC, register-file write enable and retirement count. It halts the core on `ebreak`, on an illegal opcode, or on a memory timeout.

## Interface
- `RESET_PC`, 64'h8000_0000, PC value loaded on reset
- `TIMEOUT`, 255, maximum wait cycles for an `imem_ack`/`dmem_ack` before a fault (8-bit counter)

Ports:
- `clk` in 1: single core clock; all state changes on the rising edge
- `rst` in 1: synchronous, active-high reset
- `imem_req` out 1: fetch request; equals (state==FETCH) && !rst
- `imem_addr` out 64: always equal to `pc_o`
- `imem_ack` in 1: fetch accepted; `imem_rdata` is valid in the same cycle
- `imem_rdata` in 32: fetched instruction word
- `instr_o` out 32: latched instruction, driven to the decoder
- `op` in 7, `func3` in 3, `rd` in 5, `immI` in 64: decoder fields for `instr_o`
- `next_pc` in 64: execute-unit next PC, sampled in WB
- `dmem_req` out 1: data access request; equals (state==MEM) && !rst
- `dmem_ack` in 1: data access complete
- `rf_wen` out 1: register-file write strobe, one cycle in WB
- `pc_o` out 64: current PC
- `retired` out 1: one-cycle pulse per retired instruction
- `instret` out 64: count of retired instructions
- `halt` out 1: sticky; high once state==HALT
- `halt_code` out 2: 0 = running, 1 = ebreak, 2 = illegal, 3 = timeout

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH
  - Hold `imem_req` high until `imem_req && imem_ack`.
  - On acknowledge, latch `imem_rdata` into `instr_o` and go to DECODE.
- DECODE: classify `op`.
  - Legal opcodes: 0010011 OP-IMM (any `func3`), 0110011 OP, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH.
  - SYSTEM (1110011) with `func3`==0 and `immI`==1 is `ebreak`: go to HALT with code 1. The `ebreak` counts as retired: `retired` pulses and `instret` increments on HALT entry.
  - Any other SYSTEM encoding, or any other opcode, is illegal: go to HALT with code 2, no retirement, PC unchanged.
  - All legal opcodes go to EXEC.
- EXEC: one cycle. Go to MEM for LOAD or STORE, otherwise to WB.
- MEM: hold `dmem_req` high until `dmem_ack`, then go to WB.
- WB
  - `pc_o` <= `next_pc`.
  - `retired` pulses and `instret` <= `instret`+1 (wraps modulo 2^64).
  - `rf_wen`=1 for OP-IMM, OP, LUI, AUIPC, JAL, JALR, LOAD when `rd`!=0. `rf_wen`=0 for STORE, BRANCH, or `rd`==0.
  - Next state is FETCH.
- Timeout
  - An 8-bit wait counter clears on entry to FETCH and to MEM, and increments each cycle spent waiting without an acknowledge.
  - When the counter reaches `TIMEOUT` with no acknowledge, go to HALT with code 3.
  - An acknowledge in that same cycle wins: no fault.
- HALT
  - Absorbing state: only `rst` leaves it.
  - `imem_req`, `dmem_req`, `rf_wen` and `retired` are 0.
  - `pc_o` and `instret` are frozen.
- Acknowledges arriving outside the matching wait state are ignored.

## Timing
- Reset values (rst high at an edge): state=FETCH, `pc_o`=`RESET_PC`, `instr_o`=0, `instret`=0, `halt`=0, `halt_code`=0, wait counter=0.
  - Strobes (`rf_wen`, `retired`) are 0.
  - While `rst` is high, `imem_req`=`dmem_req`=0.
- Reset mid-operation: all in-flight state is discarded, and any acknowledge in the reset cycle is ignored. The first `imem_req` is in the first cycle with `rst` low.
- Latency with zero-wait acknowledge (ack in the same cycle as req):
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE: 5 cycles.
  - Each wait cycle adds 1.
- Back-to-back: `imem_req` rises in the cycle after WB.
- `rf_wen`, `retired`, the PC update and the `instret` increment all occur in the same WB cycle. Registered values are visible after that edge.
- `instr_o` is stable from DECODE through WB. The decoder inputs are sampled combinationally in DECODE and WB.
- `halt`/`halt_code` are registered and asserted the cycle after the DECODE or timeout decision.

## Test plan
- Reset release, then `imem_ack` tied high with `imem_rdata`=32'h00100093 (addi x1,x0,1) and `next_pc`=`pc_o`+4:
  - First `imem_addr`=0x8000_0000.
  - `rf_wen` pulses every 4 cycles.
  - `pc_o` steps 0x8000_0004, 0x8000_0008, …
  - `instret`=3 after 12 cycles.
- LOAD 32'h0000_2103 with `dmem_ack` delayed 3 cycles:
  - `dmem_req` high for 4 cycles.
  - `rf_wen` fires in the following cycle.
  - Total 8 cycles.
- STORE 32'h0010_2023 and BRANCH 32'h0000_0063: `rf_wen` stays 0, `retired` pulses, `pc_o`=`next_pc`.
- `imem_rdata`=32'h0010_0073 (ebreak):
  - `halt`=1, `halt_code`=1, `instret` increments once.
  - `imem_req` stays 0 for 20+ cycles until `rst`.
- `imem_rdata`=32'h0000_0000 (illegal): `halt_code`=2, `instret` unchanged.
  - Separately, `imem_ack` never asserted: `halt_code`=3 after `TIMEOUT` wait cycles.
  - Separately, `imem_ack` first rises on the `TIMEOUT` cycle: fetch completes, no halt.
- Assert `rst` for 1 cycle during MEM wait:
  - The next cycle is FETCH at 0x8000_0000 with `instret`=0.
  - A late `dmem_ack` is ignored.
